// File: rtl/hamming_error_logger.sv
// Hamming error logger: records one entry per paused error event in a
// show-ahead FIFO and keeps saturating event and drop totals.
module hamming_error_logger #(
    parameter int WIDTH       = 4,
    parameter int BLOCKS      = WIDTH / 4,
    parameter int PARITY_BITS = BLOCKS * 3,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       counter,
    input  logic [PARITY_BITS-1:0] syndrome,
    input  logic                   error_detected,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [WIDTH-1:0]       rec_counter,
    output logic [PARITY_BITS-1:0] rec_syndrome,
    output logic [1:0]             rec_kind,
    output logic [CNT_W-1:0]       err_count,
    output logic [CNT_W-1:0]       drop_count,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LATCHED
    } state_t;

    state_t state;

    logic cond;
    logic event_e;
    logic push;
    logic pop;
    logic wr_en;
    logic drop;
    logic [1:0] kind;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic [WIDTH-1:0]       mem_counter  [DEPTH];
    logic [PARITY_BITS-1:0] mem_syndrome [DEPTH];
    logic [1:0]             mem_kind     [DEPTH];

    assign cond    = error_detected | (|syndrome);
    assign event_e = (state == ARMED) && !enable && cond;

    // Single-bit syndromes point at a parity bit, multi-bit at a data bit
    always_comb begin
        kind = 2'b00;
        for (int i = 0; i < BLOCKS; i++) begin
            case (syndrome[i*3 +: 3])
                3'b011, 3'b101, 3'b110, 3'b111: kind[0] = 1'b1;
                3'b001, 3'b010, 3'b100:         kind[1] = 1'b1;
                default: ;
            endcase
        end
    end

    assign rec_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pop   = rec_valid & rec_ready & !clear;
    assign push  = event_e & !clear;
    assign wr_en = push & (!full | pop);
    assign drop  = push & full & !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!enable) state <= ARMED;
                end
                ARMED: begin
                    if (enable)    state <= IDLE;
                    else if (cond) state <= LATCHED;
                end
                LATCHED: begin
                    if (enable)     state <= IDLE;
                    else if (!cond) state <= ARMED;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count  <= '0;
            drop_count <= '0;
        end else if (clear) begin
            err_count  <= '0;
            drop_count <= '0;
        end else begin
            if (push && !(&err_count))
                err_count <= err_count + CNT_ONE;
            if (drop && !(&drop_count))
                drop_count <= drop_count + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_counter[wr_ptr[AW-1:0]]  <= counter;
            mem_syndrome[wr_ptr[AW-1:0]] <= syndrome;
            mem_kind[wr_ptr[AW-1:0]]     <= kind;
        end
    end

    // Storage is not reset, so the head is gated to zero while empty
    assign rec_counter  = rec_valid ? mem_counter[rd_ptr[AW-1:0]]  : '0;
    assign rec_syndrome = rec_valid ? mem_syndrome[rd_ptr[AW-1:0]] : '0;
    assign rec_kind     = rec_valid ? mem_kind[rd_ptr[AW-1:0]]     : '0;

endmodule

// File: tb/tb_hamming_error_logger.sv
// Bench for hamming_error_logger: directed and random stimulus
// against a queue-based reference of paused error events.
module tb_hamming_error_logger;
    localparam int WIDTH = 8;
    localparam int PB    = 6;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic             enable = 1'b1;
    logic [WIDTH-1:0] counter = '0;
    logic [PB-1:0]    syndrome = '0;
    logic             error_detected = 1'b0;
    logic             rec_ready = 1'b0;
    logic             rec_valid;
    logic [WIDTH-1:0] rec_counter;
    logic [PB-1:0]    rec_syndrome;
    logic [1:0]       rec_kind;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] drop_count;
    logic             full;

    typedef struct {
        logic [WIDTH-1:0] c;
        logic [PB-1:0]    s;
        logic [1:0]       k;
    } rec_t;

    rec_t q[$];
    int   errs = 0;
    int   drops = 0;
    bit   was_paused = 0;
    bit   taken = 0;
    int   compared = 0;
    int   mismatched = 0;

    hamming_error_logger #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .enable(enable),
        .counter(counter),
        .syndrome(syndrome),
        .error_detected(error_detected),
        .rec_valid(rec_valid),
        .rec_ready(rec_ready),
        .rec_counter(rec_counter),
        .rec_syndrome(rec_syndrome),
        .rec_kind(rec_kind),
        .err_count(err_count),
        .drop_count(drop_count),
        .full(full)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] classify(logic [PB-1:0] s);
        logic [1:0] k;
        logic [2:0] b;
        k = 2'b00;
        for (int i = 0; i < PB / 3; i++) begin
            b = s[i*3 +: 3];
            if ($countones(b) >= 2) k[0] = 1'b1;
            if ($countones(b) == 1) k[1] = 1'b1;
        end
        return k;
    endfunction

    function automatic int sat(int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rec_valid", 32'(rec_valid), 32'(q.size() > 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("err_count", 32'(err_count), 32'(errs));
        chk("drop_count", 32'(drop_count), 32'(drops));
        if (q.size() > 0) begin
            chk("rec_counter", 32'(rec_counter), 32'(q[0].c));
            chk("rec_syndrome", 32'(rec_syndrome), 32'(q[0].s));
            chk("rec_kind", 32'(rec_kind), 32'(q[0].k));
        end
    endtask

    task automatic model_reset();
        q.delete();
        errs = 0;
        drops = 0;
        was_paused = 0;
        taken = 0;
    endtask

    // One clock: update the reference from the sampled inputs, then compare
    task automatic cycle();
        int n;
        bit pop;
        bit e;
        bit c_now;
        rec_t r;
        @(posedge clk);
        c_now = error_detected | (|syndrome);
        if (clear) begin
            model_reset();
        end else begin
            n = q.size();
            pop = (n > 0) && rec_ready;
            e = !enable && was_paused && c_now && !taken;
            if (pop) q.delete(0);
            if (e) begin
                errs = sat(errs);
                if (n == DEPTH && !pop) begin
                    drops = sat(drops);
                end else begin
                    r.c = counter;
                    r.s = syndrome;
                    r.k = classify(syndrome);
                    q.push_back(r);
                end
            end
            taken = !enable && c_now && (taken || e);
            was_paused = !enable;
        end
        #1;
        check_all();
    endtask

    task automatic step(bit en, logic [WIDTH-1:0] ctr, logic [PB-1:0] syn,
                        bit err, bit rdy, bit clr);
        enable = en;
        counter = ctr;
        syndrome = syn;
        error_detected = err;
        rec_ready = rdy;
        clear = clr;
        cycle();
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_valid"}, 32'(rec_valid), 32'd0);
        chk({tag, "_counter"}, 32'(rec_counter), 32'd0);
        chk({tag, "_syndrome"}, 32'(rec_syndrome), 32'd0);
        chk({tag, "_kind"}, 32'(rec_kind), 32'd0);
        chk({tag, "_err"}, 32'(err_count), 32'd0);
        chk({tag, "_drop"}, 32'(drop_count), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
    endtask

    initial begin
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single data-bit error held for three cycles
        step(1, 8'd0, 6'b000_000, 0, 0, 0);
        step(1, 8'd0, 6'b000_000, 0, 0, 0);
        step(0, 8'd5, 6'b000_011, 0, 0, 0);
        chk("single_not_yet", 32'(rec_valid), 32'd0);
        step(0, 8'd5, 6'b000_011, 0, 0, 0);
        chk("single_valid", 32'(rec_valid), 32'd1);
        step(0, 8'd5, 6'b000_011, 0, 0, 0);
        chk("single_err", 32'(err_count), 32'd1);
        chk("single_ctr", 32'(rec_counter), 32'd5);
        chk("single_syn", 32'(rec_syndrome), 32'd3);
        chk("single_kind", 32'(rec_kind), 32'd1);
        step(0, 8'd5, 6'b000_000, 0, 1, 0);
        chk("single_once", 32'(rec_valid), 32'd0);

        // Parity-only then mixed classification
        step(0, 8'h21, 6'b001_000, 0, 0, 0);
        chk("parity_kind", 32'(rec_kind), 32'd2);
        step(0, 8'h21, 6'b000_000, 0, 1, 0);
        step(0, 8'h22, 6'b100_111, 0, 0, 0);
        chk("mixed_kind", 32'(rec_kind), 32'd3);
        step(0, 8'h22, 6'b000_000, 0, 1, 0);

        // Overflow: six events with the reader stalled
        step(0, 8'd0, 6'b000_000, 0, 0, 1);
        step(0, 8'd0, 6'b000_000, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            step(0, 8'(i), 6'b010_000, 0, 0, 0);
            step(0, 8'd0, 6'b000_000, 0, 0, 0);
        end
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_err", 32'(err_count), 32'd6);
        chk("ovf_drop", 32'(drop_count), 32'd2);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_order", 32'(rec_counter), 32'(i));
            step(0, 8'd0, 6'b000_000, 0, 1, 0);
        end
        chk("ovf_drained", 32'(rec_valid), 32'd0);

        // Full FIFO with an event arriving alongside a pop
        for (int i = 11; i <= 14; i++) begin
            step(0, 8'(i), 6'b000_101, 0, 0, 0);
            step(0, 8'd0, 6'b000_000, 0, 0, 0);
        end
        chk("fp_full_before", 32'(full), 32'd1);
        step(0, 8'd15, 6'b000_000, 1, 1, 0);
        chk("fp_full_after", 32'(full), 32'd1);
        chk("fp_no_drop", 32'(drop_count), 32'd2);
        chk("fp_sat", 32'(err_count), 32'(CMAX));
        step(0, 8'd0, 6'b000_000, 0, 0, 0);
        for (int i = 12; i <= 15; i++) begin
            chk("fp_order", 32'(rec_counter), 32'(i));
            step(0, 8'd0, 6'b000_000, 0, 1, 0);
        end

        // Clear wins over a coincident event
        step(0, 8'd9, 6'b000_111, 0, 0, 1);
        chk("clr_err", 32'(err_count), 32'd0);
        chk("clr_drop", 32'(drop_count), 32'd0);
        chk("clr_valid", 32'(rec_valid), 32'd0);
        step(0, 8'd0, 6'b000_000, 0, 0, 0);

        // Randomized traffic, mostly paused
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 9) == 0,
                 8'($urandom),
                 ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 80) == 0);
        end

        // Asynchronous reset between edges with records pending
        step(0, 8'd0, 6'b000_000, 0, 0, 1);
        step(0, 8'd0, 6'b000_000, 0, 0, 0);
        step(0, 8'h31, 6'b000_001, 0, 0, 0);
        step(0, 8'd0, 6'b000_000, 0, 0, 0);
        step(0, 8'h32, 6'b000_110, 0, 0, 0);
        step(0, 8'd0, 6'b000_000, 0, 0, 0);
        chk("pre_rst_two", 32'(rec_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async");
        model_reset();
        #2;
        rst = 1'b0;
        step(1, 8'd0, 6'b000_000, 0, 0, 0);
        step(0, 8'd0, 6'b000_000, 0, 0, 0);
        step(0, 8'h40, 6'b000_000, 1, 0, 0);
        chk("post_rst_err", 32'(err_count), 32'd1);
        chk("post_rst_ctr", 32'(rec_counter), 32'h40);
        chk("post_rst_kind", 32'(rec_kind), 32'd0);

        // Enable rising while the error persists adds nothing
        step(1, 8'h41, 6'b000_000, 1, 0, 0);
        chk("en_rise_err", 32'(err_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule

// File: doc/hamming_error_logger.md
# hamming_error_logger

Downstream monitor for the Hamming-protected counter stage. Watches the counter value, per-block syndrome and error flag produced while counting is paused. Captures one record per error event into a small show-ahead FIFO, classifying each event as data-bit or parity-bit. Keeps saturating totals of events and dropped records, and hands records to a host/debug reader over a valid/ready interface.

## Interface
- WIDTH, 4, counter width; multiple of 4
- BLOCKS, WIDTH/4, number of 4-bit Hamming blocks
- PARITY_BITS, BLOCKS*3, syndrome width
- DEPTH, 4, FIFO entries; power of 2, ≥2
- CNT_W, 8, width of the statistics counters

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous clear of FIFO, counters and FSM
- enable  in  1  counter enable of the upstream stage; high = counting
- counter  in  WIDTH  current counter value
- syndrome  in  PARITY_BITS  per-block syndrome; block i = syndrome[i*3+:3]
- error_detected  in  1  upstream error flag
- rec_valid  out  1  FIFO head holds a record
- rec_ready  in  1  reader accepts head this cycle
- rec_counter  out  WIDTH  head record counter value
- rec_syndrome  out  PARITY_BITS  head record syndrome
- rec_kind  out  2  head class: bit0 = data-bit error, bit1 = parity-bit error
- err_count  out  CNT_W  total events, saturating
- drop_count  out  CNT_W  events lost due to full FIFO, saturating
- full  out  1  FIFO holds DEPTH records

## Operation
- Condition C = error_detected | (|syndrome).
- Monitor FSM (3 states):
  - IDLE: upstream counting. To ARMED when enable = 0.
  - ARMED: paused, no event pending. If enable = 1, go to IDLE. Else if C = 1, raise event E and go to LATCHED.
  - LATCHED: event already taken. If enable = 1, go to IDLE. Else if C = 0, go to ARMED.
- E fires only on the ARMED→LATCHED transition. One record is taken per contiguous assertion of C.
- Classification per block syndrome s:
  - s ∈ {011, 101, 110, 111}: sets data bit.
  - s ∈ {001, 010, 100}: sets parity bit.
  - s = 000: no effect.
  - rec_kind is the OR over all blocks; 11 means mixed.
- On E, the record {counter, syndrome, kind} is sampled at that same clock edge.
- Write rules:
  - Not full: write at tail.
  - Full without a pop in the same cycle: record discarded, drop_count += 1.
  - Full with a pop in the same cycle: write accepted, no drop.
- err_count += 1 on every E, dropped or not.
- Both statistics counters saturate at 2^CNT_W−1.
- Read side: show-ahead. rec_* reflect the head whenever rec_valid = 1. Pop when rec_valid & rec_ready.
- rec_* are don't-care when rec_valid = 0, but must hold stable while rec_valid = 1 and rec_ready = 0.
- clear:
  - Empties the FIFO, zeroes both counters, sets FSM to IDLE.
  - Has priority over E and pop in the same cycle; that event is neither stored nor counted.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. full/empty are derived from pointer MSB comparison.

## Timing
- Reset values:
  - FSM IDLE.
  - rec_valid 0, rec_counter 0, rec_syndrome 0, rec_kind 0.
  - err_count 0, drop_count 0, full 0.
- E decided on inputs at edge N. Record visible with rec_valid = 1 at N+1. err_count/drop_count updated at N+1.
- Earliest E: the edge after enable falls, since IDLE→ARMED takes one cycle.
- Pop at edge N: next head (or rec_valid = 0) visible at N+1.
- Simultaneous push and pop on an empty FIFO is impossible (rec_valid = 0). Push and pop at one entry: head advances to the new record, occupancy unchanged.
- full asserts the cycle after the DEPTH-th write and deasserts the cycle after the first pop.
- rst mid-operation: everything returns to reset values immediately, and pending records are lost.
- enable rising while C = 1 in LATCHED: goes to IDLE with no extra record.

## Test plan
- **Single data error:** WIDTH = 4, enable 1→0, counter = 4'h5, syndrome = 3'b011 for 3 cycles. Require exactly 1 record {5, 011, kind = 01}, err_count = 1, rec_valid at the cycle after E.
- **Parity and mixed classification:** WIDTH = 8.
  - syndrome = 6'b001_000 gives kind = 10.
  - After C drops and re-asserts with 6'b100_111, require a second record with kind = 11.
- **Overflow:** DEPTH = 4, rec_ready = 0, 6 separate events. Require full = 1, 4 records stored, err_count = 6, drop_count = 2. Draining with rec_ready = 1 yields the first 4 records in order.
- **Full with simultaneous pop:** FIFO full, E in the same cycle as a pop. Require no drop, the new record stored last, full still 1.
- **Saturation and clear:** CNT_W = 2, 5 events with draining. Require err_count stuck at 3. clear asserted together with an event: counters 0, rec_valid 0, event not stored.
- **Async reset mid-operation:** rst pulsed between clock edges with 2 records queued. Require all outputs at reset values immediately. The next E after the pause produces err_count = 1.
